// File: rtl/crack_pkg.sv
// Shared definitions for the multi-lane ARC4 crack supervisor.
//   crack_state_t : supervisor FSM states
//   CODE_BLANK    : display code for a blank digit
//   CODE_DASH     : display code for a dash digit
//   lane_base_f   : first key of lane i when the key space is split evenly
package crack_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    FOUND  = 3'd3,
    FAIL   = 3'd4
  } crack_state_t;

  localparam logic [4:0] CODE_BLANK = 5'b10001;
  localparam logic [4:0] CODE_DASH  = 5'b10000;

  // Lane i starts at i placed in the top log2(num_ch) key bits. Returned wide;
  // callers truncate to their key width. For num_ch == 1 the only lane is 0.
  function automatic logic [63:0] lane_base_f(input int i, input int num_ch, input int key_w);
    int shift;
    shift = key_w - $clog2(num_ch);
    return 64'(unsigned'(i)) << shift;
  endfunction

endpackage

// File: rtl/hex_sseg.sv
// Seven-segment decoder with display flag.
//   code [4:0] in  : {flag, nibble}; flag=0 shows the hex nibble,
//                    flag=1 shows a dash for CODE_DASH, blank otherwise
//   seg  [6:0] out : active-low segments {g,f,e,d,c,b,a}
// Purely combinational.
module hex_sseg
  import crack_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    if (!code[4]) begin
      case (code[3:0])
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end else if (code == CODE_DASH) begin
      seg = 7'b0111111;
    end
  end

endmodule

// File: rtl/multicrack_ctrl.sv
// Supervisor for NUM_CH parallel ARC4 crack lanes. Splits the KEY_W-bit key
// space evenly, launches all lanes together, latches the first valid key,
// aborts the remaining lanes and drives the seven-segment digits.
// Optional watchdog enabled by defining CRACK_TIMEOUT_EN.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle search request (IDLE/FOUND/FAIL only)
//   lane_en      : one-cycle launch pulse per lane
//   lane_base    : constant first key of each lane
//   lane_abort   : one-cycle stop pulse to all lanes
//   lane_rdy     : lane idle/finished
//   lane_valid   : lane found a key (qualified by lane_rdy)
//   lane_key     : lane's candidate key
//   busy, found, timeout : status
//   key          : latched winning key
//   hex          : active-low digits, digit 0 in the LSBs
module multicrack_ctrl
  import crack_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int KEY_W          = 24,
  parameter int TIMEOUT_CYCLES = 2**26
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [NUM_CH-1:0]         lane_en,
  output logic [NUM_CH*KEY_W-1:0]   lane_base,
  output logic                      lane_abort,
  input  logic [NUM_CH-1:0]         lane_rdy,
  input  logic [NUM_CH-1:0]         lane_valid,
  input  logic [NUM_CH*KEY_W-1:0]   lane_key,
  output logic                      busy,
  output logic                      found,
  output logic                      timeout,
  output logic [KEY_W-1:0]          key,
  output logic [(KEY_W/4)*7-1:0]    hex
);

  localparam int DIGITS = KEY_W / 4;

  if (NUM_CH < 1 || NUM_CH > 16 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
    $error("multicrack_ctrl: NUM_CH must be a power of two in 1..16");
  end
  if ((KEY_W % 4) != 0 || KEY_W <= $clog2(NUM_CH)) begin : g_bad_key_w
    $error("multicrack_ctrl: KEY_W must be a multiple of 4 and exceed log2(NUM_CH)");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("multicrack_ctrl: TIMEOUT_CYCLES must be positive");
  end

  crack_state_t      state, state_n;
  logic [NUM_CH-1:0] rdy_q;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] hit;
  logic              win_any;
  logic [KEY_W-1:0]  win_key;
  logic              load_key;
  logic              abort_set;
  logic              abort_q;
  logic              expire;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_base
    assign lane_base[i*KEY_W +: KEY_W] = KEY_W'(lane_base_f(i, NUM_CH, KEY_W));
  end

  // A lane finishes on the rising edge of its rdy; a rdy held high since
  // launch never produces an edge and so never counts.
  assign rise = lane_rdy & ~rdy_q;
  assign hit  = rise & lane_valid;

`ifdef CRACK_TIMEOUT_EN
  logic [31:0] cnt;
  logic        timeout_q;
  logic        to_set;

  assign expire  = (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;
  assign to_set  = (state == RUN) && !win_any && expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else if (state == LAUNCH) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + 32'd1;
      if (to_set) timeout_q <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    lane_en   = '0;
    load_key  = 1'b0;
    abort_set = 1'b0;
    win_any   = 1'b0;
    win_key   = '0;
    case (state)
      IDLE: begin
        if (start) state_n = LAUNCH;
      end
      LAUNCH: begin
        lane_en = '1;
        state_n = RUN;
      end
      RUN: begin
        // Descending scan so the lowest-index hit is the one left standing.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (hit[i]) begin
            win_any = 1'b1;
            win_key = lane_key[i*KEY_W +: KEY_W];
          end
        end
        // Winner beats both watchdog expiry and exhaustion in the same cycle.
        if (win_any) begin
          load_key  = 1'b1;
          abort_set = 1'b1;
          state_n   = FOUND;
        end else if (expire) begin
          abort_set = 1'b1;
          state_n   = FAIL;
        end else if (&(done | rise)) begin
          state_n = FAIL;
        end
      end
      FOUND, FAIL: begin
        if (start) state_n = LAUNCH;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q   <= '1;
      done    <= '0;
      key     <= '0;
      abort_q <= 1'b0;
    end else begin
      rdy_q   <= lane_rdy;
      abort_q <= abort_set;
      if (state == LAUNCH) begin
        done <= '0;
        key  <= '0;
      end else if (state == RUN) begin
        done <= done | rise;
        if (load_key) key <= win_key;
      end
    end
  end

  assign lane_abort = abort_q;
  assign busy       = (state == LAUNCH) || (state == RUN);
  assign found      = (state == FOUND);

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [4:0] code;
    assign code = (state == FOUND) ? {1'b0, key[4*d +: 4]} :
                  (state == FAIL)  ? CODE_DASH : CODE_BLANK;
    hex_sseg u_seg (
      .code (code),
      .seg  (hex[7*d +: 7])
    );
  end

endmodule

// File: tb/tb_multicrack_ctrl.sv
module tb_multicrack_ctrl;

  localparam int NUM_CH = 2;
  localparam int KEY_W  = 24;
  localparam logic [41:0] HEX_BLANK = {6{7'h7F}};
  localparam logic [41:0] HEX_DASH  = {6{7'b0111111}};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  lane_en;
  logic [47:0] lane_base;
  logic        lane_abort;
  logic [1:0]  lane_rdy = 2'b11;
  logic [1:0]  lane_valid = 2'b00;
  logic [47:0] lane_key = '0;
  logic        busy;
  logic        found;
  logic        timeout;
  logic [23:0] key;
  logic [41:0] hex;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  multicrack_ctrl #(
    .NUM_CH         (NUM_CH),
    .KEY_W          (KEY_W),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .lane_en    (lane_en),
    .lane_base  (lane_base),
    .lane_abort (lane_abort),
    .lane_rdy   (lane_rdy),
    .lane_valid (lane_valid),
    .lane_key   (lane_key),
    .busy       (busy),
    .found      (found),
    .timeout    (timeout),
    .key        (key),
    .hex        (hex)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a search and leave the DUT in its first RUN cycle with rdy low.
  task automatic go_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    lane_rdy = 2'b00;
    lane_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (found !== 1'b0) begin failures++; $display("FAIL reset_found: got %b want 0", found); end
    tests_run++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    tests_run++; if (key !== 24'h0) begin failures++; $display("FAIL reset_key: got %h want 000000", key); end
    tests_run++; if (lane_en !== 2'b00) begin failures++; $display("FAIL reset_lane_en: got %b want 00", lane_en); end
    tests_run++; if (lane_abort !== 1'b0) begin failures++; $display("FAIL reset_abort: got %b want 0", lane_abort); end
    tests_run++; if (hex !== HEX_BLANK) begin failures++; $display("FAIL reset_hex: got %h want %h", hex, HEX_BLANK); end
    tests_run++; if (lane_base !== 48'h800000_000000) begin failures++; $display("FAIL lane_base: got %h want 800000000000", lane_base); end
  endtask

  task automatic test_win();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (lane_en !== 2'b11) begin failures++; $display("FAIL launch_lane_en: got %b want 11", lane_en); end
    tests_run++; if (busy !== 1'b1) begin failures++; $display("FAIL launch_busy: got %b want 1", busy); end
    tests_run++; if (hex !== HEX_BLANK) begin failures++; $display("FAIL launch_hex: got %h want %h", hex, HEX_BLANK); end
    lane_rdy = 2'b00;
    tick();
    tests_run++; if (lane_en !== 2'b00) begin failures++; $display("FAIL run_lane_en: got %b want 00", lane_en); end
    // start inside RUN must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (busy !== 1'b1 || lane_en !== 2'b00) begin failures++; $display("FAIL run_start_ignored: busy %b lane_en %b want 1 00", busy, lane_en); end
    lane_rdy = 2'b10;
    lane_valid = 2'b10;
    lane_key = {24'h8000A3, 24'h000000};
    tick();
    tests_run++; if (found !== 1'b1) begin failures++; $display("FAIL win_found: got %b want 1", found); end
    tests_run++; if (key !== 24'h8000A3) begin failures++; $display("FAIL win_key: got %h want 8000a3", key); end
    tests_run++; if (lane_abort !== 1'b1) begin failures++; $display("FAIL win_abort: got %b want 1", lane_abort); end
    tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL win_busy: got %b want 0", busy); end
    tests_run++; if (hex[6:0] !== 7'b0110000) begin failures++; $display("FAIL win_hex0: got %b want 0110000", hex[6:0]); end
    tests_run++; if (hex[41:35] !== 7'b0000000) begin failures++; $display("FAIL win_hex5: got %b want 0000000", hex[41:35]); end
    tests_run++; if (hex !== {7'h00, 7'h40, 7'h40, 7'h40, 7'h08, 7'h30}) begin failures++; $display("FAIL win_hex_all: got %h", hex); end
    lane_rdy = 2'b11;
    lane_valid = 2'b00;
    tick();
    tests_run++; if (lane_abort !== 1'b0) begin failures++; $display("FAIL win_abort_pulse: got %b want 0", lane_abort); end
    tests_run++; if (found !== 1'b1 || key !== 24'h8000A3) begin failures++; $display("FAIL win_hold: found %b key %h want 1 8000a3", found, key); end
  endtask

  task automatic test_simultaneous();
    go_run();
    tests_run++; if (key !== 24'h0) begin failures++; $display("FAIL relaunch_key_clear: got %h want 000000", key); end
    tests_run++; if (found !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL relaunch_state: found %b busy %b want 0 1", found, busy); end
    lane_rdy = 2'b11;
    lane_valid = 2'b11;
    lane_key = {24'h800022, 24'h000011};
    tick();
    tests_run++; if (key !== 24'h000011) begin failures++; $display("FAIL prio_key: got %h want 000011", key); end
    tests_run++; if (found !== 1'b1 || lane_abort !== 1'b1) begin failures++; $display("FAIL prio_found: found %b abort %b want 1 1", found, lane_abort); end
    lane_valid = 2'b00;
  endtask

  task automatic test_exhaust();
    go_run();
    lane_rdy = 2'b01;
    tick();
    tests_run++; if (busy !== 1'b1 || found !== 1'b0) begin failures++; $display("FAIL exh_partial: busy %b found %b want 1 0", busy, found); end
    lane_rdy = 2'b11;
    tick();
    tests_run++; if (busy !== 1'b0 || found !== 1'b0) begin failures++; $display("FAIL exh_state: busy %b found %b want 0 0", busy, found); end
    tests_run++; if (hex !== HEX_DASH) begin failures++; $display("FAIL exh_hex: got %h want %h", hex, HEX_DASH); end
    tests_run++; if (lane_abort !== 1'b0) begin failures++; $display("FAIL exh_abort: got %b want 0", lane_abort); end
    tick();
    tests_run++; if (lane_abort !== 1'b0 || hex !== HEX_DASH) begin failures++; $display("FAIL exh_hold: abort %b hex %h", lane_abort, hex); end
  endtask

  task automatic test_reset_mid_run();
    go_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0 || found !== 1'b0) begin failures++; $display("FAIL rst_run_state: busy %b found %b want 0 0", busy, found); end
    tests_run++; if (lane_abort !== 1'b0) begin failures++; $display("FAIL rst_run_abort: got %b want 0", lane_abort); end
    tests_run++; if (hex !== HEX_BLANK || key !== 24'h0) begin failures++; $display("FAIL rst_run_out: hex %h key %h", hex, key); end
    lane_rdy = 2'b11;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (lane_en !== 2'b11) begin failures++; $display("FAIL rst_relaunch: got %b want 11", lane_en); end
    lane_rdy = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lane_rdy = 2'b11;
    tick();
  endtask

  task automatic test_timeout();
`ifdef CRACK_TIMEOUT_EN
    go_run();
    repeat (99) tick();
    tests_run++; if (busy !== 1'b1 || timeout !== 1'b0 || lane_abort !== 1'b0) begin failures++; $display("FAIL to_early: busy %b timeout %b abort %b want 1 0 0", busy, timeout, lane_abort); end
    tick();
    tests_run++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_flag: got %b want 1", timeout); end
    tests_run++; if (lane_abort !== 1'b1) begin failures++; $display("FAIL to_abort: got %b want 1", lane_abort); end
    tests_run++; if (busy !== 1'b0 || hex !== HEX_DASH) begin failures++; $display("FAIL to_state: busy %b hex %h", busy, hex); end
    tick();
    tests_run++; if (lane_abort !== 1'b0 || timeout !== 1'b1) begin failures++; $display("FAIL to_hold: abort %b timeout %b want 0 1", lane_abort, timeout); end
    lane_rdy = 2'b11;
    go_run();
    tests_run++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", timeout); end
`else
    go_run();
    repeat (150) tick();
    tests_run++; if (busy !== 1'b1 || found !== 1'b0) begin failures++; $display("FAIL wait_state: busy %b found %b want 1 0", busy, found); end
    tests_run++; if (timeout !== 1'b0 || lane_abort !== 1'b0) begin failures++; $display("FAIL wait_no_timeout: timeout %b abort %b want 0 0", timeout, lane_abort); end
`endif
  endtask

  initial begin
    test_reset();
    test_win();
    test_simultaneous();
    test_exhaust();
    test_reset_mid_run();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/multicrack_ctrl.md
# multicrack_ctrl

Supervisor for NUM_CH parallel ARC4 crack lanes. It partitions the KEY_W-bit key space evenly across the lanes and launches all of them together. It collects the first valid key, aborts the remaining lanes and drives the seven-segment digits with the result. It sits between the board top level and the `crack` / `doublecrack`-style engines. It replaces the single-engine fixed 24-bit ready/valid handling with a scalable, reusable controller.

## Interface
- NUM_CH, default 2: number of crack lanes; power of two, range 1..16.
- KEY_W, default 24: key width; multiple of 4, and KEY_W > log2(NUM_CH).
- TIMEOUT_CYCLES, default 2**26: watchdog limit; used only when CRACK_TIMEOUT_EN is defined.
- clk  in  1  single clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a search.
- lane_en  out  NUM_CH  one-cycle launch pulse per lane.
- lane_base  out  NUM_CH*KEY_W  first key of lane i, equal to i << (KEY_W-log2(NUM_CH)); constant.
- lane_abort  out  1  one-cycle pulse telling all lanes to stop.
- lane_rdy  in  NUM_CH  lane idle/finished; drops the cycle after lane_en.
- lane_valid  in  NUM_CH  lane found a key; meaningful only while that lane's rdy is high.
- lane_key  in  NUM_CH*KEY_W  lane's key; meaningful with lane_valid.
- busy  out  1  search in progress.
- found  out  1  valid key latched.
- timeout  out  1  search ended by watchdog.
- key  out  KEY_W  latched winning key.
- hex  out  (KEY_W/4)*7  active-low segment patterns; digit 0 is in the LSBs.

## Operation
- The FSM has five states: IDLE, LAUNCH, RUN, FOUND, FAIL.
- **IDLE**
  - start moves the FSM to LAUNCH.
- **LAUNCH** (one cycle)
  - lane_en is all-ones.
  - The done bitmap is cleared, the key register is cleared and the watchdog counter is cleared.
  - Next state is RUN.
- **RUN**
  - lane_rdy is registered into rdy_q.
  - A lane is done on a rising edge of lane_rdy (lane_rdy & ~rdy_q); this sets done[i].
  - **Win:** if any lane has a rising edge with lane_valid high, the lowest-index such lane wins.
    - key <= lane_key[win], lane_abort pulses for one cycle, next state is FOUND.
  - **Exhausted:** if done becomes all-ones with no winner, next state is FAIL with no abort pulse.
- **FOUND / FAIL**
  - Both states hold until start; start goes to LAUNCH, which is a restart.
- **start outside IDLE/FOUND/FAIL:** ignored.
- **Simultaneous events:**
  - A winner and the last-done lane in the same cycle resolve to FOUND.
  - A valid rising edge that coincides with the watchdog expiring resolves to FOUND.
- **Outputs by state:**
  - busy = LAUNCH or RUN.
  - found is high only in FOUND.
  - key holds its value until the next LAUNCH.
- **Display:** each digit takes the 5-bit code {flag, nibble} and goes through the decoder.
  - IDLE, LAUNCH and RUN: every digit shows code 5'b10001, which is blank (7'h7F).
  - FOUND: digit d shows {1'b0, key[4d+3:4d]}; 0..F use the standard active-low patterns (0 = 7'b1000000).
  - FAIL: every digit shows code 5'b10000, which is a dash (7'b0111111).
  - The hex output is combinational from registered state and key.

## Timing
- **Reset values:**
  - State IDLE.
  - busy=0, found=0, timeout=0, key=0.
  - lane_en=0, lane_abort=0.
  - hex all 7'h7F.
  - rdy_q all-ones.
- lane_en is high in the cycle after start is sampled.
- Winner: the lane's rdy edge in cycle t gives found=1, key valid and lane_abort=1 in cycle t+1.
- Exhaustion: the final rdy edge in cycle t gives FAIL in cycle t+1.
- A lane's rdy that stays high after launch without ever dropping never counts as done. Lanes must drop rdy exactly one cycle after lane_en.
- Reset mid-RUN: return to IDLE next cycle with no lane_abort. Lanes share the same reset.

## Configuration
- **CRACK_TIMEOUT_EN defined:**
  - A 32-bit counter increments every RUN cycle.
  - On reaching TIMEOUT_CYCLES-1 with no winner: lane_abort pulses, timeout=1, state goes to FAIL.
  - timeout clears at LAUNCH.
- **CRACK_TIMEOUT_EN undefined:** no counter is built, the timeout port is tied to 0, and RUN waits indefinitely.

## Structure
- **Package crack_pkg:**
  - State enum crack_state_t.
  - Display code localparams: CODE_BLANK=5'b10001, CODE_DASH=5'b10000.
  - Function lane_base_f(i, NUM_CH, KEY_W).
- **Sub-module hex_sseg:** 5-bit code in, 7-bit active-low segments out, purely combinational. It is instantiated KEY_W/4 times with a generate loop.
- Winner selection is a priority encoder over the NUM_CH lanes, written as a for-loop inside the RUN logic.

## Test plan
All scenarios use NUM_CH=2, KEY_W=24.
- Reset, then idle → hex all 7'h7F, lane_base = {24'h800000, 24'h000000}, busy=0.
- start; lane1 rdy rises with valid and key 24'h8000A3 → found=1 one cycle later, key=24'h8000A3, lane_abort single pulse, HEX0 shows 3 (7'b0110000), HEX5 shows 8.
- Both lanes' rdy rise in the same cycle, both valid, keys 24'h000011 and 24'h800022 → key=24'h000011.
- Both lanes finish on different cycles with no valid → FAIL, every digit 7'b0111111, no lane_abort.
- reset asserted in RUN → next cycle IDLE, all outputs at reset values; a following start relaunches with lane_en=2'b11.
- With CRACK_TIMEOUT_EN and TIMEOUT_CYCLES=100, lanes never finish → after 100 RUN cycles timeout=1, lane_abort pulses, FAIL display.
